div16seq: RTL and testbench



---
 rtl/div16seq_if.sv | 25 ++
 rtl/div16seq.sv | 133 +++++++++++++
 tb/tb_div16seq.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/div16seq_if.sv
// div16seq_if: operand/result handshake bundle for the 16-bit sequential divider.
//   in_valid/in_ready   : operand handshake (dividend, divisor)
//   out_valid/out_ready : result handshake (quotient, remainder, div_by_zero)
// Modports: master = operand producer / result consumer, slave = divider.
interface div16seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div16seq.sv
// div16seq: 16-bit unsigned restoring divider, one quotient bit per clock.
// Ports:
//   i_clk : rising-edge clock
//   i_rst : synchronous, active-high reset (aborts any operation in flight)
//   bus   : div16seq_if.slave -- operand accept handshake and result
//           handshake; all bus outputs are registered.
// A zero divisor skips the iteration and reports quotient=16'hFFFF,
// remainder=dividend with div_by_zero set.
module div16seq (
  input  logic     i_clk,
  input  logic     i_rst,
  div16seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_q;          // quotient / dividend shift register
  logic [15:0] r_prem;       // partial remainder (see note on width below)
  logic [15:0] r_divisor;
  logic [3:0]  r_count;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [15:0] r_quotient;
  logic [15:0] r_remainder;
  logic        r_dbz;

  logic [16:0] w_shift;
  logic [16:0] w_trial;
  logic [15:0] w_prem_next;
  logic [15:0] w_q_next;

  // One restoring step: 17-bit trial subtraction (inverted divisor plus
  // carry-in) and restore/commit select. The partial remainder is always
  // below the divisor, so its 17th bit is identically zero and only the low
  // 16 bits are stored; the 17-bit value lives in w_shift.
  always_comb begin
    w_shift     = {r_prem, r_q[15]};
    w_trial     = w_shift + {1'b1, ~r_divisor} + 17'd1;
    w_prem_next = w_shift[15:0];
    w_q_next    = {r_q[14:0], 1'b0};
    if (w_trial[16] == 1'b0) begin
      // no borrow: commit the subtraction and retire a 1
      w_prem_next = w_trial[15:0];
      w_q_next    = {r_q[14:0], 1'b1};
    end else begin
      // borrow: keep the shifted remainder and retire a 0
      w_prem_next = w_shift[15:0];
      w_q_next    = {r_q[14:0], 1'b0};
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_q         <= 16'h0000;
      r_prem      <= 16'h0000;
      r_divisor   <= 16'h0000;
      r_count     <= 4'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quotient  <= 16'h0000;
      r_remainder <= 16'h0000;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            if (bus.divisor == 16'h0000) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_quotient  <= 16'hFFFF;
              r_remainder <= bus.dividend;
              r_dbz       <= 1'b1;
            end else begin
              r_state   <= ST_CALC;
              r_divisor <= bus.divisor;
              r_q       <= bus.dividend;
              r_prem    <= 16'h0000;
              r_count   <= 4'd0;
              r_dbz     <= 1'b0;
            end
          end else begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        ST_CALC: begin
          r_prem  <= w_prem_next;
          r_q     <= w_q_next;
          r_count <= r_count + 4'd1;
          if (r_count == 4'd15) begin
            // last step: publish the step's result directly
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_quotient  <= w_q_next;
            r_remainder <= w_prem_next;
          end else begin
            r_state <= ST_CALC;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end else begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_count     <= 4'd0;
        end
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_div16seq.sv
// tb_div16seq: self-checking bench for div16seq (directed table, hand-written
// backpressure/reset sequences, randomized operands against an arithmetic
// reference model).
module tb_div16seq;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  div16seq_if u_if ();

  div16seq u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          lat;   // clock edges after the accept edge until out_valid
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Accept one operand pair and wait for the result; leaves it in DONE.
  task automatic run_div(input logic [15:0] a, input logic [15:0] b, output int lat,
                         output logic [15:0] q, output logic [15:0] r, output logic dbz);
    int n;
    n = 0;
    while (u_if.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_timeout", {31'd0, n >= 50}, 32'd0);
    u_if.in_valid = 1'b1;
    u_if.dividend = a;
    u_if.divisor  = b;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    u_if.dividend = 16'($urandom);  // operands need not be held
    u_if.divisor  = 16'($urandom);
    lat = 0;
    while (u_if.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk("out_valid_timeout", {31'd0, lat >= 100}, 32'd0);
    q   = u_if.quotient;
    r   = u_if.remainder;
    dbz = u_if.div_by_zero;
  endtask

  // Complete the result handshake and check the return to IDLE.
  task automatic finish_out(input string tag);
    u_if.out_ready = 1'b1;
    @(posedge clk); #1;
    u_if.out_ready = 1'b0;
    chk({tag, "_in_ready_after"}, {31'd0, u_if.in_ready}, 32'd1);
    chk({tag, "_out_valid_after"}, {31'd0, u_if.out_valid}, 32'd0);
  endtask

  initial begin
    int          lat;
    logic [15:0] q, r, a, b, eq, er;
    logic        dbz, edbz;

    checks   = 0;
    failures = 0;
    vecs[0] = '{16'd100,   16'd7,     16'd14,    16'd2,  1'b0, 16};
    vecs[1] = '{16'hFFFF,  16'd1,     16'hFFFF,  16'd0,  1'b0, 16};
    vecs[2] = '{16'h8000,  16'h8000,  16'd1,     16'd0,  1'b0, 16};
    vecs[3] = '{16'd3,     16'd10,    16'd0,     16'd3,  1'b0, 16};
    vecs[4] = '{16'hFFFF,  16'hFFFF,  16'd1,     16'd0,  1'b0, 16};
    vecs[5] = '{16'd5,     16'd0,     16'hFFFF,  16'd5,  1'b1, 0};
    vecs[6] = '{16'd9,     16'd3,     16'd3,     16'd0,  1'b0, 16};

    rst = 1'b1;
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b0;
    u_if.dividend  = 16'd0;
    u_if.divisor   = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, u_if.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, u_if.out_valid}, 32'd0);
    chk("rst_quotient", {16'd0, u_if.quotient}, 32'd0);
    chk("rst_remainder", {16'd0, u_if.remainder}, 32'd0);
    chk("rst_dbz", {31'd0, u_if.div_by_zero}, 32'd0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_div(vecs[i].a, vecs[i].b, lat, q, r, dbz);
      chk($sformatf("vec%0d_quotient", i), {16'd0, q}, {16'd0, vecs[i].q});
      chk($sformatf("vec%0d_remainder", i), {16'd0, r}, {16'd0, vecs[i].r});
      chk($sformatf("vec%0d_dbz", i), {31'd0, dbz}, {31'd0, vecs[i].dbz});
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_in_ready_done", i), {31'd0, u_if.in_ready}, 32'd0);
      finish_out($sformatf("vec%0d", i));
    end

    // Backpressure: results held, in_ready low, new operands ignored
    run_div(16'd1000, 16'd33, lat, q, r, dbz);
    for (int c = 0; c < 5; c++) begin
      chk("bp_quotient", {16'd0, u_if.quotient}, 32'd30);
      chk("bp_remainder", {16'd0, u_if.remainder}, 32'd10);
      chk("bp_in_ready", {31'd0, u_if.in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, u_if.out_valid}, 32'd1);
      u_if.in_valid = 1'b1;
      u_if.dividend = 16'd7;
      u_if.divisor  = 16'd1;
      @(posedge clk); #1;
    end
    chk("bp_quotient_end", {16'd0, u_if.quotient}, 32'd30);
    chk("bp_remainder_end", {16'd0, u_if.remainder}, 32'd10);
    u_if.in_valid = 1'b0;
    finish_out("bp");

    // Reset mid-CALC aborts the operation
    u_if.in_valid = 1'b1;
    u_if.dividend = 16'd40000;
    u_if.divisor  = 16'd123;
    @(posedge clk); #1;
    u_if.in_valid = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("midcalc_out_valid", {31'd0, u_if.out_valid}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", {31'd0, u_if.in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, u_if.out_valid}, 32'd0);
    chk("abort_quotient", {16'd0, u_if.quotient}, 32'd0);
    chk("abort_remainder", {16'd0, u_if.remainder}, 32'd0);
    chk("abort_dbz", {31'd0, u_if.div_by_zero}, 32'd0);
    run_div(16'd40000, 16'd123, lat, q, r, dbz);
    chk("post_rst_quotient", {16'd0, q}, 32'd325);
    chk("post_rst_remainder", {16'd0, r}, 32'd25);
    chk("post_rst_latency", lat, 16);
    finish_out("post_rst");

    // Randomized operands vs. arithmetic reference model
    for (int k = 0; k < 60; k++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 15));
        2:       b = a;
        default: b = 16'($urandom);
      endcase
      if (b == 16'd0) begin
        eq = 16'hFFFF; er = a; edbz = 1'b1;
      end else begin
        eq = a / b; er = a % b; edbz = 1'b0;
      end
      run_div(a, b, lat, q, r, dbz);
      chk($sformatf("rnd%0d_%0d/%0d_quotient", k, a, b), {16'd0, q}, {16'd0, eq});
      chk($sformatf("rnd%0d_%0d/%0d_remainder", k, a, b), {16'd0, r}, {16'd0, er});
      chk($sformatf("rnd%0d_dbz", k), {31'd0, dbz}, {31'd0, edbz});
      chk($sformatf("rnd%0d_latency", k), lat, (b == 16'd0) ? 0 : 16);
      if (b != 16'd0) begin
        chk($sformatf("rnd%0d_identity", k), 32'(q) * 32'(b) + 32'(r), 32'(a));
      end else begin
        chk($sformatf("rnd%0d_zero_rem", k), {16'd0, r}, {16'd0, a});
      end
      finish_out($sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
